// File: rtl/mul_rs_dispatch.sv
// Multiply/divide reservation station: operand capture at issue or from the CDB,
// oldest-ready-first dispatch of one operation at a time to the mul/div unit.
module mul_rs_dispatch #(
  parameter int N_ENT = 3
) (
  input  logic       clk2,
  input  logic       rst_n,
  input  logic       iss_valid,
  output logic       iss_ready,
  input  logic [3:0] iss_func,
  input  logic [3:0] iss_rd,
  input  logic [2:0] iss_rob,
  input  logic       iss_v1,
  input  logic [7:0] iss_d1,
  input  logic [3:0] iss_q1,
  input  logic       iss_v2,
  input  logic [7:0] iss_d2,
  input  logic [3:0] iss_q2,
  input  logic       cdb_valid,
  input  logic [3:0] cdb_tag,
  input  logic [7:0] cdb_data,
  input  logic       ex_done,
  output logic       ex_b,
  output logic [2:0] rs_index,
  output logic [7:0] rs1_data,
  output logic [7:0] rs2_data,
  output logic [3:0] func,
  output logic [3:0] rd,
  output logic [2:0] rob_ind,
  output logic [1:0] mul_count,
  output logic       iss_err
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_q, state_d;

  logic [N_ENT-1:0] busy_q, busy_d, exec_q, exec_d, v1_q, v1_d, v2_q, v2_d;
  logic [3:0] func_q [N_ENT];
  logic [3:0] func_d [N_ENT];
  logic [3:0] rd_q   [N_ENT];
  logic [3:0] rd_d   [N_ENT];
  logic [2:0] rob_q  [N_ENT];
  logic [2:0] rob_d  [N_ENT];
  logic [3:0] q1_q   [N_ENT];
  logic [3:0] q1_d   [N_ENT];
  logic [3:0] q2_q   [N_ENT];
  logic [3:0] q2_d   [N_ENT];
  logic [7:0] d1_q   [N_ENT];
  logic [7:0] d1_d   [N_ENT];
  logic [7:0] d2_q   [N_ENT];
  logic [7:0] d2_d   [N_ENT];
  logic [1:0] age_q  [N_ENT];
  logic [1:0] age_d  [N_ENT];

  logic [1:0] count_q, count_d;
  logic       ex_b_q, err_q;
  logic [2:0] idx_q, rob_ind_q;
  logic [7:0] rs1_q, rs2_q;
  logic [3:0] func_out_q, rd_out_q;

  logic             legal, accept, do_free, dispatch, any_elig;
  logic [N_ENT-1:0] elig;
  logic [2:0]       free_idx, sel_idx, sel_rob;
  logic [1:0]       sel_age;
  logic [7:0]       sel_d1, sel_d2;
  logic [3:0]       sel_func, sel_rd;

  assign iss_ready = ~&busy_q;
  assign legal     = (iss_func == 4'b0010) || (iss_func == 4'b0011);
  assign accept    = iss_valid && iss_ready && legal;
  assign elig      = busy_q & ~exec_q & v1_q & v2_q;
  assign do_free   = (state_q == S_WAIT) && ex_done;

  // Strict '>' keeps the lower index on equal age.
  always_comb begin : pick
    free_idx = '0;
    sel_idx  = '0;
    sel_age  = '0;
    any_elig = 1'b0;
    sel_d1   = '0;
    sel_d2   = '0;
    sel_func = '0;
    sel_rd   = '0;
    sel_rob  = '0;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = 3'(i);
    end
    for (int i = 0; i < N_ENT; i++) begin
      if (elig[i] && (!any_elig || age_q[i] > sel_age)) begin
        any_elig = 1'b1;
        sel_idx  = 3'(i);
        sel_age  = age_q[i];
        sel_d1   = d1_q[i];
        sel_d2   = d2_q[i];
        sel_func = func_q[i];
        sel_rd   = rd_q[i];
        sel_rob  = rob_q[i];
      end
    end
  end

  always_comb begin : fsm
    state_d  = state_q;
    dispatch = 1'b0;
    case (state_q)
      S_IDLE: if (any_elig) begin
        dispatch = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: if (ex_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : entry_next
    busy_d = busy_q;
    exec_d = exec_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    func_d = func_q;
    rd_d   = rd_q;
    rob_d  = rob_q;
    q1_d   = q1_q;
    q2_d   = q2_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    age_d  = age_q;
    for (int i = 0; i < N_ENT; i++) begin
      if (cdb_valid && busy_q[i] && !v1_q[i] && q1_q[i] == cdb_tag) begin
        v1_d[i] = 1'b1;
        d1_d[i] = cdb_data;
      end
      if (cdb_valid && busy_q[i] && !v2_q[i] && q2_q[i] == cdb_tag) begin
        v2_d[i] = 1'b1;
        d2_d[i] = cdb_data;
      end
      if (accept && busy_q[i] && age_q[i] != 2'd3) age_d[i] = age_q[i] + 2'd1;
      if (dispatch && sel_idx == 3'(i)) exec_d[i] = 1'b1;
      if (do_free && idx_q == 3'(i)) begin
        busy_d[i] = 1'b0;
        exec_d[i] = 1'b0;
        v1_d[i]   = 1'b0;
        v2_d[i]   = 1'b0;
        age_d[i]  = 2'd0;
      end
      // The free entry comes from registered busy, so it never collides with do_free.
      if (accept && free_idx == 3'(i)) begin
        busy_d[i] = 1'b1;
        exec_d[i] = 1'b0;
        func_d[i] = iss_func;
        rd_d[i]   = iss_rd;
        rob_d[i]  = iss_rob;
        age_d[i]  = 2'd0;
        q1_d[i]   = iss_q1;
        q2_d[i]   = iss_q2;
        v1_d[i]   = iss_v1 || (cdb_valid && cdb_tag == iss_q1);
        d1_d[i]   = iss_v1 ? iss_d1 : cdb_data;
        v2_d[i]   = iss_v2 || (cdb_valid && cdb_tag == iss_q2);
        d2_d[i]   = iss_v2 ? iss_d2 : cdb_data;
      end
    end
    count_d = count_q;
    if (accept && !do_free)      count_d = count_q + 2'd1;
    else if (!accept && do_free) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= '0;
      exec_q     <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      count_q    <= '0;
      ex_b_q     <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      func_out_q <= '0;
      rd_out_q   <= '0;
      rob_ind_q  <= '0;
      for (int i = 0; i < N_ENT; i++) begin
        func_q[i] <= '0;
        rd_q[i]   <= '0;
        rob_q[i]  <= '0;
        q1_q[i]   <= '0;
        q2_q[i]   <= '0;
        d1_q[i]   <= '0;
        d2_q[i]   <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      exec_q  <= exec_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      count_q <= count_d;
      ex_b_q  <= dispatch;
      err_q   <= iss_valid && !legal;
      for (int i = 0; i < N_ENT; i++) begin
        func_q[i] <= func_d[i];
        rd_q[i]   <= rd_d[i];
        rob_q[i]  <= rob_d[i];
        q1_q[i]   <= q1_d[i];
        q2_q[i]   <= q2_d[i];
        d1_q[i]   <= d1_d[i];
        d2_q[i]   <= d2_d[i];
        age_q[i]  <= age_d[i];
      end
      if (dispatch) begin
        idx_q      <= sel_idx;
        rs1_q      <= sel_d1;
        rs2_q      <= sel_d2;
        func_out_q <= sel_func;
        rd_out_q   <= sel_rd;
        rob_ind_q  <= sel_rob;
      end
    end
  end

  assign ex_b      = ex_b_q;
  assign iss_err   = err_q;
  assign mul_count = count_q;
  assign rs_index  = idx_q;
  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;
  assign func      = func_out_q;
  assign rd        = rd_out_q;
  assign rob_ind   = rob_ind_q;
endmodule

// File: tb/tb_mul_rs_dispatch.sv
// Bench for mul_rs_dispatch: vector table, directed multi-cycle sequences,
// then randomized traffic against an entry-level reference model.
module tb_mul_rs_dispatch;
  localparam int N = 3;

  logic       clk2 = 1'b0;
  logic       rst_n = 1'b0;
  logic       iss_valid, iss_ready;
  logic [3:0] iss_func, iss_rd;
  logic [2:0] iss_rob;
  logic       iss_v1, iss_v2;
  logic [7:0] iss_d1, iss_d2;
  logic [3:0] iss_q1, iss_q2;
  logic       cdb_valid;
  logic [3:0] cdb_tag;
  logic [7:0] cdb_data;
  logic       ex_done, ex_b, iss_err;
  logic [2:0] rs_index, rob_ind;
  logic [7:0] rs1_data, rs2_data;
  logic [3:0] func, rd;
  logic [1:0] mul_count;

  int checks = 0;
  int errors = 0;

  always #5 clk2 = ~clk2;

  mul_rs_dispatch #(.N_ENT(N)) dut (
    .clk2(clk2), .rst_n(rst_n), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_func(iss_func), .iss_rd(iss_rd), .iss_rob(iss_rob),
    .iss_v1(iss_v1), .iss_d1(iss_d1), .iss_q1(iss_q1),
    .iss_v2(iss_v2), .iss_d2(iss_d2), .iss_q2(iss_q2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_done(ex_done), .ex_b(ex_b), .rs_index(rs_index),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .func(func), .rd(rd),
    .rob_ind(rob_ind), .mul_count(mul_count), .iss_err(iss_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_func = 0; iss_rd = 0; iss_rob = 0;
    iss_v1 = 0; iss_d1 = 0; iss_q1 = 0; iss_v2 = 0; iss_d2 = 0; iss_q2 = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; ex_done = 0;
  endtask

  task automatic drive_issue(input logic [3:0] f, input logic [3:0] r, input logic [2:0] rob,
                             input logic v1, input logic [7:0] d1, input logic [3:0] q1,
                             input logic v2, input logic [7:0] d2, input logic [3:0] q2);
    iss_valid = 1; iss_func = f; iss_rd = r; iss_rob = rob;
    iss_v1 = v1; iss_d1 = d1; iss_q1 = q1; iss_v2 = v2; iss_d2 = d2; iss_q2 = q2;
  endtask

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic done_pulse();
    ex_done = 1;
    tick();
    ex_done = 0;
  endtask

  // Vector table: single issue with both operands ready.
  typedef struct {
    logic [3:0] f;
    logic [3:0] r;
    logic [2:0] rob;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       exp_err;
  } vec_t;
  vec_t vecs[6];

  // Reference model: each entry remembers its issue sequence number; age is
  // the number of later issues, saturated at 3.
  typedef struct {
    bit busy; bit exec;
    logic [3:0] f; logic [3:0] r; logic [2:0] rob;
    bit v1; logic [7:0] d1; logic [3:0] q1;
    bit v2; logic [7:0] d2; logic [3:0] q2;
    int seq;
  } ment_t;
  ment_t m[N];
  int    m_issues, m_exec;
  bit    m_wait;
  bit    e_exb, e_err;
  int    e_idx, e_d1, e_d2, e_f, e_rd, e_rob;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m[i].busy = 0; m[i].exec = 0; m[i].v1 = 0; m[i].v2 = 0; m[i].seq = 0;
    end
    m_issues = 0; m_exec = 0; m_wait = 0; e_exb = 0; e_err = 0;
    e_idx = 0; e_d1 = 0; e_d2 = 0; e_f = 0; e_rd = 0; e_rob = 0;
  endtask

  task automatic model_step();
    int  freei = -1;
    int  best = -1;
    int  bage = -1;
    int  age;
    bit  legal = (iss_func == 4'd2) || (iss_func == 4'd3);
    bit  accept, do_free;
    for (int i = 0; i < N; i++) if (!m[i].busy && freei < 0) freei = i;
    accept  = iss_valid && (freei >= 0) && legal;
    do_free = m_wait && ex_done;
    if (!m_wait) begin
      for (int i = 0; i < N; i++) begin
        if (m[i].busy && !m[i].exec && m[i].v1 && m[i].v2) begin
          age = (m_issues - m[i].seq > 3) ? 3 : m_issues - m[i].seq;
          if (age > bage) begin best = i; bage = age; end
        end
      end
    end
    e_err = iss_valid && !legal;
    e_exb = (best >= 0);
    if (best >= 0) begin
      e_idx = best; e_d1 = m[best].d1; e_d2 = m[best].d2;
      e_f = m[best].f; e_rd = m[best].r; e_rob = m[best].rob;
      m[best].exec = 1; m_wait = 1; m_exec = best;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && cdb_valid && !m[i].v1 && m[i].q1 == cdb_tag) begin
        m[i].v1 = 1; m[i].d1 = cdb_data;
      end
      if (m[i].busy && cdb_valid && !m[i].v2 && m[i].q2 == cdb_tag) begin
        m[i].v2 = 1; m[i].d2 = cdb_data;
      end
    end
    if (do_free) begin
      m[m_exec].busy = 0; m[m_exec].exec = 0; m_wait = 0;
    end
    if (accept) begin
      m_issues++;
      m[freei].busy = 1; m[freei].exec = 0; m[freei].seq = m_issues;
      m[freei].f = iss_func; m[freei].r = iss_rd; m[freei].rob = iss_rob;
      m[freei].q1 = iss_q1; m[freei].q2 = iss_q2;
      if (iss_v1) begin m[freei].v1 = 1; m[freei].d1 = iss_d1; end
      else if (cdb_valid && cdb_tag == iss_q1) begin m[freei].v1 = 1; m[freei].d1 = cdb_data; end
      else m[freei].v1 = 0;
      if (iss_v2) begin m[freei].v2 = 1; m[freei].d2 = iss_d2; end
      else if (cdb_valid && cdb_tag == iss_q2) begin m[freei].v2 = 1; m[freei].d2 = cdb_data; end
      else m[freei].v2 = 0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m[i].busy) c++;
    return c;
  endfunction

  initial begin
    idle_inputs();
    vecs[0] = '{4'h2, 4'h3, 3'h2, 8'd5,   8'd7,   1'b0};
    vecs[1] = '{4'h3, 4'h1, 3'h5, 8'hff,  8'h00,  1'b0};
    vecs[2] = '{4'h2, 4'hf, 3'h7, 8'h80,  8'h01,  1'b0};
    vecs[3] = '{4'h1, 4'h2, 3'h0, 8'd1,   8'd1,   1'b1};
    vecs[4] = '{4'h0, 4'h4, 3'h4, 8'd9,   8'd9,   1'b1};
    vecs[5] = '{4'h3, 4'h0, 3'h0, 8'h3c,  8'hc3,  1'b0};

    // Reset state
    #2;
    chk("rst_ex_b", ex_b, 0);
    chk("rst_iss_err", iss_err, 0);
    chk("rst_count", mul_count, 0);
    chk("rst_ready", iss_ready, 1);
    chk("rst_rs1", rs1_data, 0);
    chk("rst_func", func, 0);
    #10 rst_n = 1;

    // Table: first entry is issued on the very first edge after reset release
    for (int i = 0; i < 6; i++) begin
      drive_issue(vecs[i].f, vecs[i].r, vecs[i].rob, 1, vecs[i].d1, 4'd0, 1, vecs[i].d2, 4'd0);
      tick();
      idle_inputs();
      if (vecs[i].exp_err) begin
        chk("err_pulse", iss_err, 1);
        chk("err_count", mul_count, 0);
        tick();
        chk("err_clear", iss_err, 0);
        chk("err_no_exb", ex_b, 0);
      end else begin
        chk("vec_count", mul_count, 1);
        chk("vec_no_early_exb", ex_b, 0);
        tick();
        chk("vec_exb", ex_b, 1);
        chk("vec_index", rs_index, 0);
        chk("vec_rs1", rs1_data, vecs[i].d1);
        chk("vec_rs2", rs2_data, vecs[i].d2);
        chk("vec_func", func, vecs[i].f);
        chk("vec_rd", rd, vecs[i].r);
        chk("vec_rob", rob_ind, vecs[i].rob);
        done_pulse();
        chk("vec_freed", mul_count, 0);
        chk("vec_exb_one_cycle", ex_b, 0);
        chk("vec_hold", rs1_data, vecs[i].d1);
      end
      $display("vector %0d func=%0h err=%0b applied", i, vecs[i].f, vecs[i].exp_err);
    end

    // Operand 2 woken by CDB two cycles after issue
    drive_issue(4'h3, 4'd6, 3'd1, 1, 8'd3, 4'd0, 0, 8'd0, 4'd4);
    tick(); idle_inputs();
    chk("cdb_wait_count", mul_count, 1);
    tick();
    chk("cdb_wait_no_exb", ex_b, 0);
    cdb_valid = 1; cdb_tag = 4; cdb_data = 8'd9;
    tick(); idle_inputs();
    chk("cdb_wake_no_exb", ex_b, 0);
    tick();
    chk("cdb_exb", ex_b, 1);
    chk("cdb_rs2", rs2_data, 9);
    chk("cdb_rs1", rs1_data, 3);
    done_pulse();
    $display("seq cdb wakeup done");

    // Same-cycle CDB bypass at issue
    drive_issue(4'h2, 4'd5, 3'd3, 0, 8'd0, 4'd6, 1, 8'd2, 4'd0);
    cdb_valid = 1; cdb_tag = 6; cdb_data = 8'h11;
    tick(); idle_inputs();
    tick();
    chk("bypass_exb", ex_b, 1);
    chk("bypass_rs1", rs1_data, 8'h11);
    done_pulse();
    $display("seq bypass done");

    // ex_done in IDLE ignored; non-matching CDB tag ignored
    drive_issue(4'h2, 4'd1, 3'd1, 0, 8'd0, 4'd7, 1, 8'd4, 4'd0);
    tick(); idle_inputs();
    done_pulse();
    chk("idle_done_ignored", mul_count, 1);
    cdb_valid = 1; cdb_tag = 8; cdb_data = 8'h55;
    tick(); idle_inputs();
    tick();
    chk("nomatch_no_exb", ex_b, 0);
    cdb_valid = 1; cdb_tag = 7; cdb_data = 8'h22;
    tick(); idle_inputs();
    tick();
    chk("match_exb", ex_b, 1);
    chk("match_rs1", rs1_data, 8'h22);
    done_pulse();
    chk("match_freed", mul_count, 0);
    $display("seq idle done / cdb nomatch done");

    // Fill, reject when full, dispatch oldest first
    drive_issue(4'h2, 4'd1, 3'd1, 1, 8'd1, 4'd0, 1, 8'd1, 4'd0);
    tick();
    drive_issue(4'h2, 4'd2, 3'd2, 1, 8'd2, 4'd0, 1, 8'd2, 4'd0);
    tick();
    chk("fill_exb0", ex_b, 1);
    chk("fill_idx0", rs_index, 0);
    drive_issue(4'h3, 4'd3, 3'd3, 1, 8'd3, 4'd0, 1, 8'd3, 4'd0);
    tick();
    chk("fill_count3", mul_count, 3);
    chk("fill_not_ready", iss_ready, 0);
    drive_issue(4'h3, 4'd4, 3'd4, 1, 8'd4, 4'd0, 1, 8'd4, 4'd0);
    tick(); idle_inputs();
    chk("fill_4th_dropped", mul_count, 3);
    chk("fill_gated", ex_b, 0);
    done_pulse();
    chk("fill_free0", mul_count, 2);
    chk("fill_no_same_cycle", ex_b, 0);
    tick();
    chk("fill_exb1", ex_b, 1);
    chk("fill_idx1", rs_index, 1);
    chk("fill_rs1_1", rs1_data, 2);
    done_pulse();
    chk("fill_free1", mul_count, 1);
    tick();
    chk("fill_exb2", ex_b, 1);
    chk("fill_idx2", rs_index, 2);
    chk("fill_rs1_2", rs1_data, 3);
    done_pulse();
    chk("fill_empty", mul_count, 0);
    $display("seq fill/oldest-first done");

    // Reset while in WAIT with two entries busy
    drive_issue(4'h2, 4'd1, 3'd1, 1, 8'd8, 4'd0, 1, 8'd8, 4'd0);
    tick();
    drive_issue(4'h3, 4'd2, 3'd2, 1, 8'd9, 4'd0, 1, 8'd9, 4'd0);
    tick(); idle_inputs();
    chk("wait_busy2", mul_count, 2);
    #2 rst_n = 0;
    #1;
    chk("async_rst_count", mul_count, 0);
    chk("async_rst_exb", ex_b, 0);
    chk("async_rst_ready", iss_ready, 1);
    chk("async_rst_rs1", rs1_data, 0);
    @(negedge clk2);
    rst_n = 1;
    ex_done = 1;
    drive_issue(4'h2, 4'd7, 3'd6, 1, 8'd40, 4'd0, 1, 8'd41, 4'd0);
    tick(); idle_inputs();
    chk("post_rst_accept", mul_count, 1);
    chk("post_rst_no_exb", ex_b, 0);
    tick();
    chk("post_rst_exb", ex_b, 1);
    chk("post_rst_idx", rs_index, 0);
    chk("post_rst_rs2", rs2_data, 41);
    done_pulse();
    $display("seq reset-in-wait done");

    // Randomized traffic against the reference model
    rst_n = 0;
    tick();
    rst_n = 1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int r = $urandom % 8;
      iss_valid = ($urandom % 3) != 0;
      iss_func  = (r < 3) ? 4'd2 : (r < 6) ? 4'd3 : 4'($urandom % 16);
      iss_rd    = 4'($urandom); iss_rob = 3'($urandom);
      iss_v1    = 1'($urandom); iss_d1 = 8'($urandom); iss_q1 = 4'($urandom % 6);
      iss_v2    = 1'($urandom); iss_d2 = 8'($urandom); iss_q2 = 4'($urandom % 6);
      cdb_valid = 1'($urandom); cdb_tag = 4'($urandom % 6); cdb_data = 8'($urandom);
      ex_done   = ($urandom % 4) == 0;
      model_step();
      tick();
      chk("rnd_ready", iss_ready, (model_count() < N) ? 1 : 0);
      chk("rnd_count", mul_count, model_count());
      chk("rnd_exb", ex_b, e_exb);
      chk("rnd_err", iss_err, e_err);
      chk("rnd_idx", rs_index, e_idx);
      chk("rnd_rs1", rs1_data, e_d1);
      chk("rnd_rs2", rs2_data, e_d2);
      chk("rnd_func", func, e_f);
      chk("rnd_rd", rd, e_rd);
      chk("rnd_rob", rob_ind, e_rob);
    end
    idle_inputs();
    $display("random phase: 3000 cycles applied");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_rs_dispatch.md
MUL_RS_DISPATCH -- requirements
Module: mul_rs_dispatch

Interface
REQ-001 SHALL have parameter N_ENT, default 3, giving the number of multiply/divide reservation-station entries (indices 0..N_ENT-1).
REQ-002 SHALL have clk2  in  1: sole clock; all state updates on posedge clk2.
REQ-003 SHALL have rst_n  in  1: asynchronous, active-low reset.
REQ-004 SHALL have iss_valid  in  1: issue request from the issue stage.
REQ-005 SHALL have iss_ready  out  1: high when at least one entry is free, derived from registered state only.
REQ-006 SHALL have iss_func  in  4 (0010 mul, 0011 div), iss_rd  in  4 (destination register/tag), and iss_rob  in  3 (ROB index).
REQ-007 SHALL have, for operands k = 1 and 2: iss_vk  in  1 (operand ready), iss_dk  in  8 (operand data), and iss_qk  in  4 (producer tag when not ready).
REQ-008 SHALL have cdb_valid  in  1, cdb_tag  in  4, and cdb_data  in  8: result broadcast (low byte of result).
REQ-009 SHALL have ex_done  in  1: one-cycle completion pulse from the mul/div execution unit.
REQ-010 SHALL have ex_b  out  1: one-cycle dispatch strobe to the execution unit.
REQ-011 SHALL have dispatch payload outputs rs_index  out  3, rs1_data  out  8, rs2_data  out  8, func  out  4, rd  out  4, and rob_ind  out  3.
REQ-012 SHALL have mul_count  out  2: number of occupied entries.
REQ-013 SHALL have iss_err  out  1: one-cycle pulse when an issue is rejected for an illegal func.

Function
REQ-014 Each entry SHALL hold busy, exec, func, rd, rob, v1, q1, d1, v2, q2, d2, and a 2-bit age.
REQ-015 An issue SHALL be accepted when iss_valid and iss_ready are both high and iss_func is 0010 or 0011; the entry written SHALL be the lowest-index free entry.
REQ-016 An issue with any other iss_func SHALL be dropped, with no state change and iss_err pulsed high the following cycle.
REQ-017 On issue, operand k SHALL be captured as ready with iss_dk if iss_vk=1; otherwise as ready with cdb_data if cdb_valid=1 and cdb_tag=iss_qk in the same cycle (bypass); otherwise it SHALL be stored waiting on iss_qk.
REQ-018 Each cycle with cdb_valid=1, every busy entry with a waiting operand whose q matches cdb_tag SHALL set that operand's v and load cdb_data.
REQ-019 An entry SHALL be eligible when busy=1, exec=0, v1=1, and v2=1.
REQ-020 Dispatch SHALL use a two-state FSM on clk2, IDLE and WAIT; reset state SHALL be IDLE.
REQ-021 In IDLE with at least one eligible entry, the FSM SHALL select the oldest eligible entry (largest age; equal age resolved to lower index), register its payload onto the outputs, pulse ex_b high for exactly one cycle, set the entry's exec bit, and go to WAIT.
REQ-022 In WAIT, ex_b SHALL be 0, and ex_done=1 SHALL free the exec entry (busy=0, exec=0) and return the FSM to IDLE; no dispatch SHALL occur in that same cycle.
REQ-023 Earliest dispatch SHALL be the cycle after issue, when both operands were ready at issue; latency SHALL be one clock from the eligibility-making edge to ex_b.
REQ-024 Payload outputs SHALL hold their values from the ex_b cycle until the next dispatch.
REQ-025 Age SHALL be set to 0 for a newly issued entry and incremented for every other busy entry, saturating at 3; freeing an entry SHALL NOT change other entries' ages.
REQ-026 mul_count SHALL update on the edge of each issue or free; a simultaneous issue and free SHALL leave the count unchanged.
REQ-027 When full (mul_count = N_ENT), iss_ready SHALL be 0; an entry freed in cycle T SHALL be issuable no earlier than T+1.
REQ-028 ex_done asserted while in IDLE SHALL be ignored.
REQ-029 A CDB tag matching no waiting operand SHALL have no effect.

Reset
REQ-030 While rst_n=0, all entries SHALL be cleared to busy=0, exec=0, v=0, age=0, and the FSM SHALL be IDLE, regardless of any operation in progress, including WAIT.
REQ-031 While rst_n=0, outputs SHALL be: ex_b=0, iss_err=0, mul_count=0, iss_ready=1, and all payload outputs 0.
REQ-032 After rst_n deasserts, the first posedge clk2 SHALL accept an issue.

Verification
REQ-033 Issue mul with d1=5, d2=7, both ready, rob=2, rd=3 -> ex_b the next cycle with rs_index=0, rs1_data=5, rs2_data=7, func=0010, rd=3, rob_ind=2; ex_done -> mul_count=0.
REQ-034 Issue div with q2=4 not ready; CDB tag=4, data=9 two cycles later -> ex_b the following cycle with rs2_data=9.
REQ-035 Issue with iss_q1=6 not ready while CDB tag=6, data=0x11 in the same cycle (bypass) -> dispatch the next cycle with rs1_data=0x11.
REQ-036 Fill 3 entries -> iss_ready=0, and a 4th issue is dropped; entries dispatch oldest first (index 0, 1, 2), each ex_b gated by the preceding ex_done.
REQ-037 Issue func=0001 -> iss_err pulses high, mul_count is unchanged, and no ex_b is produced.
REQ-038 Assert rst_n=0 while in WAIT with 2 entries busy -> immediately mul_count=0, ex_b=0; a later ex_done produces no change.
